// File: rtl/fir_mc_package.sv
// fir_mc_engine shared types: FSM states, latched config, width helpers.
package fir_mc_package;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT_X,
    S_MAC,
    S_OUT
  } state_e;

  localparam int CFG_N_W = 16;
  localparam int CFG_D_W = 4;
  localparam int CFG_S_W = 8;

  typedef struct packed {
    logic [CFG_N_W-1:0] n;
    logic [CFG_D_W-1:0] d;
    logic [CFG_S_W-1:0] s;
  } cfg_t;

  function automatic int acc_width(
    input int dw,
    input int nt
  );
    return 2 * dw + $clog2(nt);
  endfunction

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_NB_TAPS    = 32;
  localparam int DEF_ACC_WIDTH  =
    acc_width(DEF_DATA_WIDTH, DEF_NB_TAPS);

endpackage

// File: rtl/fir_mc_delay_line.sv
// Per-channel circular sample history; read is by offset
// back from the newest sample of the selected channel.
module fir_mc_delay_line
  import fir_mc_package::*;
#(
  parameter int DW          = DEF_DATA_WIDTH,
  parameter int NB_TAPS     = DEF_NB_TAPS,
  parameter int NB_CHANNELS = 4,
  localparam int CW = (NB_CHANNELS > 1) ? $clog2(NB_CHANNELS) : 1,
  localparam int TW = (NB_TAPS > 1) ? $clog2(NB_TAPS) : 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clear_i,
  input  logic          wr_en_i,
  input  logic [CW-1:0] wr_chan_i,
  input  logic [DW-1:0] wr_data_i,
  input  logic [CW-1:0] rd_chan_i,
  input  logic [TW-1:0] rd_off_i,
  output logic [DW-1:0] rd_data_o
);

  logic [DW-1:0] mem_q [NB_CHANNELS][NB_TAPS];
  logic [TW-1:0] wp_q  [NB_CHANNELS];
  logic [TW-1:0] rp;
  int            ri;

  // wp points at the next free slot, so newest is wp-1
  always_comb begin
    ri = int'(wp_q[rd_chan_i]) - 1 - int'(rd_off_i);
    if (ri < 0) ri = ri + NB_TAPS;
    rp = TW'(ri);
    rd_data_o = mem_q[rd_chan_i][rp];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int c = 0; c < NB_CHANNELS; c++) begin
        wp_q[c] <= '0;
        for (int t = 0; t < NB_TAPS; t++)
          mem_q[c][t] <= '0;
      end
    end else if (clear_i) begin
      for (int c = 0; c < NB_CHANNELS; c++) begin
        wp_q[c] <= '0;
        for (int t = 0; t < NB_TAPS; t++)
          mem_q[c][t] <= '0;
      end
    end else if (wr_en_i) begin
      mem_q[wr_chan_i][wp_q[wr_chan_i]] <= wr_data_i;
      wp_q[wr_chan_i] <=
        (wp_q[wr_chan_i] == TW'(NB_TAPS - 1)) ?
        '0 : wp_q[wr_chan_i] + 1'b1;
    end
  end

endmodule

// File: rtl/fir_mc_engine.sv
// Multichannel decimating FIR, one MAC per cycle.
// Define FIR_MC_SATURATE_EN to clamp outputs instead of wrapping.
module fir_mc_engine
  import fir_mc_package::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int NB_TAPS     = DEF_NB_TAPS,
  parameter int NB_CHANNELS = 4,
  parameter int ACC_WIDTH   = acc_width(DATA_WIDTH, NB_TAPS),
  localparam int NW = $clog2(NB_TAPS + 1),
  localparam int SW = $clog2(ACC_WIDTH),
  localparam int CW = (NB_CHANNELS > 1) ? $clog2(NB_CHANNELS) : 1,
  localparam int TW = (NB_TAPS > 1) ? $clog2(NB_TAPS) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clear_i,
  input  logic [NW-1:0]         cfg_nb_taps_i,
  input  logic [3:0]            cfg_decim_i,
  input  logic [SW-1:0]         cfg_shift_i,
  input  logic                  h_valid_i,
  output logic                  h_ready_o,
  input  logic [DATA_WIDTH-1:0] h_data_i,
  input  logic                  x_valid_i,
  output logic                  x_ready_o,
  input  logic [DATA_WIDTH-1:0] x_data_i,
  output logic                  y_valid_o,
  input  logic                  y_ready_i,
  output logic [DATA_WIDTH-1:0] y_data_o,
  output logic [CW-1:0]         y_chan_o,
  output logic                  busy_o,
  output logic                  taps_loaded_o
);

  state_e state_q, state_d;
  cfg_t   cfg_q, cfg_in;

  logic h_fire, x_fire, y_fire;
  logic compute, tap_last, mac_last;

  logic [DATA_WIDTH-1:0] taps_q [NB_TAPS];
  logic [3:0]            dcnt_q [NB_CHANNELS];
  logic [TW-1:0]         tcnt_q, kcnt_q;
  logic [CW-1:0]         chan_q, chan_nx;
  logic [DATA_WIDTH-1:0] y_q, x_k;
  logic                  taps_loaded_q;

  logic signed [2*DATA_WIDTH-1:0] prod;
  logic signed [ACC_WIDTH-1:0]    acc_q, acc_sum;
  logic signed [ACC_WIDTH:0]      rnd_half, rnd_sum, shifted;

`ifdef FIR_MC_SATURATE_EN
  localparam logic signed [ACC_WIDTH:0] YMAX =
    {{(ACC_WIDTH + 2 - DATA_WIDTH){1'b0}},
     {(DATA_WIDTH - 1){1'b1}}};
  localparam logic signed [ACC_WIDTH:0] YMIN = ~YMAX;
`endif

  function automatic logic [DATA_WIDTH-1:0] reduce(
    input logic signed [ACC_WIDTH:0] v
  );
`ifdef FIR_MC_SATURATE_EN
    if (v > YMAX) return YMAX[DATA_WIDTH-1:0];
    if (v < YMIN) return YMIN[DATA_WIDTH-1:0];
    return v[DATA_WIDTH-1:0];
`else
    return v[DATA_WIDTH-1:0];
`endif
  endfunction

  always_comb begin
    cfg_in = '0;
    unique case (1'b1)
      (cfg_nb_taps_i == '0):
        cfg_in.n = CFG_N_W'(1);
      (cfg_nb_taps_i > NW'(NB_TAPS)):
        cfg_in.n = CFG_N_W'(NB_TAPS);
      default:
        cfg_in.n = CFG_N_W'(cfg_nb_taps_i);
    endcase
    cfg_in.d = (cfg_decim_i == '0) ? 4'd1 : cfg_decim_i;
    cfg_in.s = CFG_S_W'(cfg_shift_i);
  end

  assign h_fire   = h_ready_o & h_valid_i;
  assign x_fire   = x_ready_o & x_valid_i;
  assign y_fire   = y_valid_o & y_ready_i;
  assign compute  = (dcnt_q[chan_q] == '0);
  assign tap_last = CFG_N_W'(tcnt_q) == cfg_q.n - 1'b1;
  assign mac_last = CFG_N_W'(kcnt_q) == cfg_q.n - 1'b1;
  assign chan_nx  = (chan_q == CW'(NB_CHANNELS - 1)) ?
                    '0 : chan_q + 1'b1;

  fir_mc_delay_line #(
    .DW          (DATA_WIDTH),
    .NB_TAPS     (NB_TAPS),
    .NB_CHANNELS (NB_CHANNELS)
  ) u_dline (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .clear_i   (clear_i),
    .wr_en_i   (x_fire & ~clear_i),
    .wr_chan_i (chan_q),
    .wr_data_i (x_data_i),
    .rd_chan_i (chan_q),
    .rd_off_i  (kcnt_q),
    .rd_data_o (x_k)
  );

  assign prod    = $signed(taps_q[kcnt_q]) * $signed(x_k);
  assign acc_sum = acc_q + ACC_WIDTH'(prod);

  // one extra bit so the rounding term cannot overflow
  always_comb begin
    rnd_half = '0;
    if (cfg_q.s != '0)
      rnd_half = (ACC_WIDTH + 1)'(1) << (cfg_q.s - 1'b1);
    rnd_sum = (ACC_WIDTH + 1)'(acc_sum) + rnd_half;
    shifted = rnd_sum >>> cfg_q.s;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   state_d = S_LOAD;
      S_LOAD:   if (h_fire && tap_last) state_d = S_WAIT_X;
      S_WAIT_X: if (x_fire && compute)  state_d = S_MAC;
      S_MAC:    if (mac_last)           state_d = S_OUT;
      S_OUT:    if (y_ready_i)          state_d = S_WAIT_X;
      default:  state_d = S_IDLE;
    endcase
    if (clear_i) state_d = S_IDLE;
  end

  always_comb begin
    h_ready_o = 1'b0;
    x_ready_o = 1'b0;
    y_valid_o = 1'b0;
    busy_o    = 1'b1;
    unique case (state_q)
      S_IDLE:   busy_o = 1'b0;
      S_LOAD:   h_ready_o = 1'b1;
      S_WAIT_X: begin
        x_ready_o = 1'b1;
        busy_o    = 1'b0;
      end
      S_OUT:    y_valid_o = 1'b1;
      default:  ;
    endcase
  end

  // coefficients survive a soft clear
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int t = 0; t < NB_TAPS; t++)
        taps_q[t] <= '0;
    end else if (h_fire && !clear_i) begin
      taps_q[tcnt_q] <= h_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cfg_q         <= '0;
      tcnt_q        <= '0;
      kcnt_q        <= '0;
      chan_q        <= '0;
      acc_q         <= '0;
      y_q           <= '0;
      taps_loaded_q <= 1'b0;
      for (int c = 0; c < NB_CHANNELS; c++)
        dcnt_q[c] <= '0;
    end else if (clear_i) begin
      cfg_q         <= '0;
      tcnt_q        <= '0;
      kcnt_q        <= '0;
      chan_q        <= '0;
      acc_q         <= '0;
      y_q           <= '0;
      taps_loaded_q <= 1'b0;
      for (int c = 0; c < NB_CHANNELS; c++)
        dcnt_q[c] <= '0;
    end else begin
      if (state_q == S_IDLE) cfg_q <= cfg_in;
      if (h_fire) begin
        tcnt_q <= tcnt_q + 1'b1;
        if (tap_last) taps_loaded_q <= 1'b1;
      end
      if (x_fire) begin
        dcnt_q[chan_q] <=
          (dcnt_q[chan_q] == cfg_q.d - 1'b1) ?
          '0 : dcnt_q[chan_q] + 1'b1;
        acc_q  <= '0;
        kcnt_q <= '0;
        if (!compute) chan_q <= chan_nx;
      end
      if (state_q == S_MAC) begin
        acc_q  <= acc_sum;
        kcnt_q <= kcnt_q + 1'b1;
        if (mac_last) y_q <= reduce(shifted);
      end
      if (y_fire) chan_q <= chan_nx;
    end
  end

  assign y_data_o      = y_q;
  assign y_chan_o      = chan_q;
  assign taps_loaded_o = taps_loaded_q;

endmodule

// File: doc/fir_mc_engine.md
FIR_MC_ENGINE -- requirements
Module: fir_mc_engine

Interface
REQ-001 Parameter DATA_WIDTH, default 16: signed width of sample, tap and output words.
REQ-002 Parameter NB_TAPS, default 32: maximum taps; delay-line depth per channel.
REQ-003 Parameter NB_CHANNELS, default 4: interleaved input channels, each with its own delay line.
REQ-004 Parameter ACC_WIDTH, default 2*DATA_WIDTH+$clog2(NB_TAPS): accumulator width.
REQ-005 clk_i  in  1  single clock; all logic on its rising edge.
REQ-006 rst_ni  in  1  reset, asynchronous and active-low.
REQ-007 clear_i  in  1  synchronous soft clear.
REQ-008 cfg_nb_taps_i  in  $clog2(NB_TAPS+1)  active taps n.
REQ-009 cfg_decim_i  in  4  decimation factor D.
REQ-010 cfg_shift_i  in  $clog2(ACC_WIDTH)  output right-shift s.
REQ-011 h_valid_i / h_ready_o / h_data_i  in/out/in  1/1/DATA_WIDTH  serial tap stream.
REQ-012 x_valid_i / x_ready_o / x_data_i  in/out/in  1/1/DATA_WIDTH  sample stream, channels strictly round-robin 0..NB_CHANNELS-1.
REQ-013 y_valid_o / y_ready_i / y_data_o / y_chan_o  out/in/out/out  1/1/DATA_WIDTH/$clog2(NB_CHANNELS)  output stream with channel tag.
REQ-014 busy_o  out  1  FSM not in IDLE or WAIT_X; taps_loaded_o  out  1  all n taps received.

Function
REQ-015 FSM states: IDLE, LOAD, WAIT_X, MAC, OUT; transfers occur when valid and ready are both high.
REQ-016 IDLE -> LOAD one cycle after reset or clear; n, D and s latch at that transition and hold until the next clear.
REQ-017 n=0 and D=0 SHALL each be treated as 1; n>NB_TAPS SHALL be treated as NB_TAPS.
REQ-018 LOAD: h_ready_o=1; tap k is stored at index k in arrival order; after the n-th tap, taps_loaded_o=1 and the FSM goes to WAIT_X.
REQ-019 WAIT_X: x_ready_o=1 only in this state; accepted sample for channel c is written to c's circular line and c's write pointer advances modulo NB_TAPS.
REQ-020 Per-channel decimation counter: output is computed only when the counter is 0 (first sample after clear computes); counter wraps at D-1; non-computing samples return to WAIT_X in the next cycle.
REQ-021 MAC: exactly n cycles, one product per cycle, acc += h[k]*x_c[newest-k], k=0..n-1; products are full-precision signed and acc is ACC_WIDTH.
REQ-022 Samples older than those received since clear read as 0.
REQ-023 Result = (acc + 2^(s-1)) >>> s, round-half-up; for s=0 no rounding term; reduced to DATA_WIDTH per REQ-031.
REQ-024 OUT: y_valid_o=1; y_data_o and y_chan_o are stable until y_ready_i; on transfer go to WAIT_X and advance the expected channel.
REQ-025 Latency: x accepted at cycle t -> y_valid_o rises at cycle t+1+n when y_ready_i stays high.
REQ-026 Throughput with y_ready_i high: one computing sample per n+2 cycles.
REQ-027 h_valid_i outside LOAD is ignored; h_ready_o=0.

Reset
REQ-028 Reset or clear: FSM=IDLE, all handshake outputs 0, busy_o=0, taps_loaded_o=0, y_data_o=0, y_chan_o=0, pointers, counters and delay lines zeroed; taps are zeroed by reset only.
REQ-029 Clear in any state, including MAC or OUT, aborts the operation next cycle with no output transfer.
REQ-030 Clear asserted together with a handshake SHALL drop that transfer.

Configuration
REQ-031 Macro FIR_MC_SATURATE_EN defined: the shifted result clamps to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1]; undefined: it truncates to the low DATA_WIDTH bits (two's-complement wrap).

Structure
REQ-032 A shared fir_mc_package SHALL hold the FSM state enum, a config struct for n, D and s, and ACC_WIDTH helper constants.
REQ-033 One sub-module, fir_mc_delay_line, SHALL hold the NB_CHANNELS x NB_TAPS circular storage with write and read-by-offset ports.

Verification
REQ-034 Use n=4, taps {1,2,3,4}, s=0, D=1, 1 channel, impulse x=1,0,0,0 -> y=1,2,3,4.
REQ-035 Use NB_CHANNELS=2, n=1, tap 1, D=2, ch0 samples 5,6,7 -> ch0 outputs 5 and 7 tagged chan 0; ch1 tagged chan 1.
REQ-036 Use n=2, taps {16384,16384}, s=14, two samples of 32767 -> with the macro y=32767 (saturated); without it the wrapped low 16 bits.
REQ-037 Use y_ready_i=0 for 10 cycles in OUT -> y_data_o stable, x_ready_o=0, no lost sample.
REQ-038 Assert clear during MAC, reload taps -> no output; the next impulse response starts from a zeroed history.
REQ-039 Use n=0 and D=0 -> behaves as n=1 and D=1; latency checked at t+2.
